// File: rtl/morse_pkg.sv
// Shared Morse definitions: state encoding, unit constants and element limit.
// The WGAP state is present only when MORSE_TX_WORDGAP_EN is defined.
package morse_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      MARK  = 3'd1,
      SPACE = 3'd2,
`ifdef MORSE_TX_WORDGAP_EN
      CGAP  = 3'd3,
      WGAP  = 3'd4
`else
      CGAP  = 3'd3
`endif
   } morse_state_e;

   localparam int unsigned DOT_U     = 1;
   localparam int unsigned DASH_U    = 3;
   localparam int unsigned CGAP_U    = 3;
   localparam int unsigned WGAP_U    = 4;
   localparam int unsigned MAX_ELEMS = 5;

   // Lengths 6 and 7 are treated as a full five-element character.
   function automatic logic [2:0] clamp_len(input logic [2:0] len);
      return (len > 3'(MAX_ELEMS)) ? 3'(MAX_ELEMS) : len;
   endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Down-counter pacing Morse elements; load takes priority and expire flags a zero count.
module morse_unit_timer #(
   parameter int unsigned WID = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           load,
   input  logic [WID-1:0] load_val,
   output logic           expire
);

   logic [WID-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (count_q != '0) begin
         count_d = count_q - 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expire = (count_q == '0);

endmodule

// File: rtl/morse_tx.sv
// Morse transmitter: keys one valid/ready character at a time with unit timing.
// Optional word-space support is enabled by defining MORSE_TX_WORDGAP_EN.
module morse_tx #(
   parameter int unsigned WID    = 32,
   parameter int unsigned UNIT   = 10,
   parameter int unsigned DASH_U = 3,
   parameter int unsigned CGAP_U = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sym_valid,
   output logic       sym_ready,
   input  logic [2:0] sym_len,
   input  logic [4:0] sym_bits,
   output logic       sig_out,
   output logic       busy,
   output logic       done
);

   import morse_pkg::*;

   localparam longint unsigned MAX_U =
      (DASH_U > CGAP_U) ? ((DASH_U > WGAP_U) ? DASH_U : WGAP_U)
                        : ((CGAP_U > WGAP_U) ? CGAP_U : WGAP_U);

   if (UNIT < 1) begin : g_unit_chk
      $error("morse_tx: UNIT must be at least 1");
   end
   if (((MAX_U * longint'(UNIT)) >> WID) != 0) begin : g_width_chk
      $error("morse_tx: longest duration does not fit in WID bits");
   end

   localparam logic [WID-1:0] DOT_LOAD  = WID'(DOT_U * UNIT - 1);
   localparam logic [WID-1:0] DASH_LOAD = WID'(DASH_U * UNIT - 1);
   localparam logic [WID-1:0] CGAP_LOAD = WID'(CGAP_U * UNIT - 1);
`ifdef MORSE_TX_WORDGAP_EN
   localparam logic [WID-1:0] WGAP_LOAD = WID'(WGAP_U * UNIT - 1);
`endif

   morse_state_e   state_q, state_d;
   logic [2:0]     len_q, len_d;
   logic [4:0]     bits_q, bits_d;
   logic [2:0]     idx_q, idx_d;
   logic [2:0]     idx_inc;
   logic           sig_out_q, sig_out_d;
   logic           busy_q, busy_d;
   logic           done_q, done_d;
   logic           accept;
   logic           tmr_load;
   logic [WID-1:0] tmr_load_val;
   logic           tmr_expire;

   morse_unit_timer #(.WID(WID)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .expire   (tmr_expire)
   );

   assign sym_ready = (state_q == IDLE) & ~reset;
   assign accept    = sym_valid & sym_ready;
   assign idx_inc   = idx_q + 3'd1;

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_d      = state_q;
      len_d        = len_q;
      bits_d       = bits_q;
      idx_d        = idx_q;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_load_val = '0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sym_len == 3'd0) begin
`ifdef MORSE_TX_WORDGAP_EN
                  state_d      = WGAP;
                  tmr_load     = 1'b1;
                  tmr_load_val = WGAP_LOAD;
`else
                  done_d       = 1'b1;
`endif
               end else begin
                  len_d        = clamp_len(sym_len);
                  bits_d       = sym_bits;
                  idx_d        = 3'd0;
                  state_d      = MARK;
                  tmr_load     = 1'b1;
                  tmr_load_val = sym_bits[0] ? DASH_LOAD : DOT_LOAD;
               end
            end
         end
         MARK: begin
            if (tmr_expire) begin
               tmr_load = 1'b1;
               if (idx_inc < len_q) begin
                  state_d      = SPACE;
                  tmr_load_val = DOT_LOAD;
               end else begin
                  state_d      = CGAP;
                  tmr_load_val = CGAP_LOAD;
               end
            end
         end
         SPACE: begin
            if (tmr_expire) begin
               idx_d        = idx_inc;
               state_d      = MARK;
               tmr_load     = 1'b1;
               tmr_load_val = bits_q[idx_inc] ? DASH_LOAD : DOT_LOAD;
            end
         end
         CGAP: begin
            if (tmr_expire) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`ifdef MORSE_TX_WORDGAP_EN
         WGAP: begin
            if (tmr_expire) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase

      sig_out_d = (state_d == MARK);
      busy_d    = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         bits_q    <= '0;
         idx_q     <= '0;
         sig_out_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         bits_q    <= bits_d;
         idx_q     <= idx_d;
         sig_out_q <= sig_out_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign sig_out = sig_out_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// Directed bench for morse_tx with UNIT=4; per-cycle waveform comparisons
// against a unit-count model of the expected keying.
module tb_morse_tx;

   localparam int unsigned UNIT_C = 4;

   logic       clk;
   logic       reset;
   logic       sym_valid;
   logic       sym_ready;
   logic [2:0] sym_len;
   logic [4:0] sym_bits;
   logic       sig_out;
   logic       busy;
   logic       done;

   int vectors;
   int errors;

   bit exp_sig [0:255];
   int exp_len;

   morse_tx #(.WID(32), .UNIT(UNIT_C), .DASH_U(3), .CGAP_U(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .sym_len   (sym_len),
      .sym_bits  (sym_bits),
      .sig_out   (sig_out),
      .busy      (busy),
      .done      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Expected sig_out for cycles t1..exp_len; the last entry is the done cycle.
   task automatic build_wave(input logic [2:0] len, input logic [4:0] bits);
      int eff;
      eff = (len > 3'd5) ? 5 : int'(len);
      exp_len = 0;
      for (int e = 0; e < eff; e++) begin
         for (int c = 0; c < (bits[e] ? 3 * UNIT_C : UNIT_C); c++) begin
            exp_len++;
            exp_sig[exp_len] = 1'b1;
         end
         if (e < eff - 1) begin
            for (int c = 0; c < UNIT_C; c++) begin
               exp_len++;
               exp_sig[exp_len] = 1'b0;
            end
         end
      end
      for (int c = 0; c < 3 * UNIT_C; c++) begin
         exp_len++;
         exp_sig[exp_len] = 1'b0;
      end
      exp_len++;
      exp_sig[exp_len] = 1'b0;
   endtask

   // Offers one character, optionally scrambles the inputs once busy, and
   // compares every output on every cycle through the done pulse.
   task automatic send_and_compare(input string name, input logic [2:0] len,
                                   input logic [4:0] bits, input bit scramble);
      build_wave(len, bits);
      sym_len   = len;
      sym_bits  = bits;
      sym_valid = 1'b1;
      vectors++;
      if (sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_at_t0: got %b want 1", name, sym_ready);
      end
      next_cycle();
      sym_valid = 1'b0;
      if (scramble) begin
         sym_len  = 3'd1;
         sym_bits = ~bits;
      end
      for (int k = 1; k <= exp_len; k++) begin
         vectors++;
         if (sig_out !== exp_sig[k] || done !== (k == exp_len) ||
             busy !== (k < exp_len) || sym_ready !== (k == exp_len)) begin
            errors++;
            $display("FAIL %s t%0d: sig/done/busy/ready got %b%b%b%b want %b%b%b%b",
                     name, k, sig_out, done, busy, sym_ready,
                     exp_sig[k], (k == exp_len), (k < exp_len), (k == exp_len));
         end
         if (scramble && k == 6) begin
            sym_len  = 3'd5;
            sym_bits = 5'b10101;
         end
         if (k < exp_len) next_cycle();
      end
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      sym_valid = 1'b0;
      sym_len   = 3'd0;
      sym_bits  = 5'd0;
      repeat (3) next_cycle();
      vectors++;
      if (sig_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sym_ready !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: sig/busy/done/ready got %b%b%b%b want 0000",
                  sig_out, busy, done, sym_ready);
      end
      reset = 1'b0;
      #1;
      vectors++;
      if (sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: got %b want 1", sym_ready);
      end
      next_cycle();
   endtask

   task automatic test_letter_a();
      send_and_compare("letter_A", 3'd2, 5'b00010, 1'b0);
   endtask

   task automatic test_back_to_back();
      // E held valid, then T offered immediately; T must wait for E's done cycle.
      sym_len   = 3'd1;
      sym_bits  = 5'b00000;
      sym_valid = 1'b1;
      next_cycle();
      sym_bits = 5'b00001;
      for (int k = 1; k <= 17; k++) begin
         vectors++;
         if (sig_out !== (k <= 4) || done !== (k == 17) || sym_ready !== (k == 17)) begin
            errors++;
            $display("FAIL b2b_E t%0d: sig/done/ready got %b%b%b want %b%b%b",
                     k, sig_out, done, sym_ready, (k <= 4), (k == 17), (k == 17));
         end
         next_cycle();
      end
      sym_valid = 1'b0;
      for (int k = 18; k <= 42; k++) begin
         vectors++;
         if (sig_out !== (k <= 29) || done !== (k == 42) || busy !== (k < 42)) begin
            errors++;
            $display("FAIL b2b_T t%0d: sig/done/busy got %b%b%b want %b%b%b",
                     k, sig_out, done, busy, (k <= 29), (k == 42), (k < 42));
         end
         if (k < 42) next_cycle();
      end
      next_cycle();
   endtask

   task automatic test_clamp();
      send_and_compare("clamp_len7", 3'd7, 5'b11111, 1'b0);
      vectors++;
      if (exp_len != 89) begin
         errors++;
         $display("FAIL clamp_model_len: got %0d want 89", exp_len);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid_char();
      int done_seen;
      sym_len   = 3'd2;
      sym_bits  = 5'b00010;
      sym_valid = 1'b1;
      next_cycle();
      sym_valid = 1'b0;
      repeat (9) next_cycle();
      vectors++;
      if (sig_out !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_pre t10: sig/busy got %b%b want 11", sig_out, busy);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if (sym_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_ready_low: got %b want 0", sym_ready);
      end
      next_cycle();
      reset = 1'b0;
      #1;
      vectors++;
      if (sig_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_after: sig/busy/done/ready got %b%b%b%b want 0001",
                  sig_out, busy, done, sym_ready);
      end
      done_seen = 0;
      for (int k = 0; k < 40; k++) begin
         next_cycle();
         if (done === 1'b1 || sig_out === 1'b1) done_seen++;
      end
      vectors++;
      if (done_seen != 0) begin
         errors++;
         $display("FAIL rst_mid_quiet: got %0d active cycles want 0", done_seen);
      end
   endtask

   task automatic test_word_space();
      sym_len   = 3'd0;
      sym_bits  = 5'b10110;
      sym_valid = 1'b1;
      next_cycle();
      sym_valid = 1'b0;
`ifdef MORSE_TX_WORDGAP_EN
      for (int k = 1; k <= 17; k++) begin
         vectors++;
         if (sig_out !== 1'b0 || done !== (k == 17) || busy !== (k < 17)) begin
            errors++;
            $display("FAIL wordgap t%0d: sig/done/busy got %b%b%b want 0%b%b",
                     k, sig_out, done, busy, (k == 17), (k < 17));
         end
         if (k < 17) next_cycle();
      end
`else
      vectors++;
      if (sig_out !== 1'b0 || done !== 1'b1 || busy !== 1'b0 || sym_ready !== 1'b1) begin
         errors++;
         $display("FAIL len0 t1: sig/done/busy/ready got %b%b%b%b want 0101",
                  sig_out, done, busy, sym_ready);
      end
      next_cycle();
      vectors++;
      if (done !== 1'b0 || sig_out !== 1'b0) begin
         errors++;
         $display("FAIL len0 t2: done/sig got %b%b want 00", done, sig_out);
      end
`endif
      next_cycle();
   endtask

   task automatic test_input_stability();
      send_and_compare("stable_inputs", 3'd2, 5'b00010, 1'b1);
      sym_len  = 3'd0;
      sym_bits = 5'd0;
      next_cycle();
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      test_reset();
      test_letter_a();
      next_cycle();
      test_back_to_back();
      test_clamp();
      test_reset_mid_char();
      test_word_space();
      test_input_stability();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
